// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: opcodes, NOP, fetch FSM encoding and fault codes.
// Latency: n/a (constants and a pure helper only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_SQUASH = 2'd1;
    localparam logic [1:0] S_VALID  = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    localparam logic [1:0] FAULT_NONE        = 2'b00;
    localparam logic [1:0] FAULT_ACK_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_MISALIGNED  = 2'b10;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts request cycles left waiting for an ack; flags the cycle the count reaches ACK_TIMEOUT.
// Latency: expired_o is combinational in the cycle the limit is reached.
// Backpressure: none; clear has priority over counting.
module fetch_watchdog #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the waiting cycle that would bring the count up to the limit.
    assign expired_o = cnt_en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, req/ack imem port, valid/ready handoff to decode, redirects, ack watchdog.
// Latency: ack in request cycle k -> inst_valid_o on cycle k+1; one instruction per 2 cycles at best.
// Backpressure: holds inst/pc while inst_ready_i is low; holds req/addr until imem_ack_i.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [6:0]      inst_opcode_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fault_o,
    output logic [1:0]      fault_code_o
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [31:0]     inst_q, inst_d;
    logic            fault_q, fault_d;
    logic [1:0]      fault_code_q, fault_code_d;

    logic redirect_ok, redirect_bad;
    logic wdog_clr, wdog_en, wdog_expired;

    assign redirect_ok  = redirect_i &&  is_word_aligned(redirect_pc_i[1:0]);
    assign redirect_bad = redirect_i && !is_word_aligned(redirect_pc_i[1:0]);

    // Reset drops the request combinationally so an in-flight fetch is abandoned at once.
    assign imem_req_o  = !rst_i && ((state_q == S_FETCH) || (state_q == S_SQUASH));
    assign imem_addr_o = (state_q == S_SQUASH) ? req_addr_q : pc_q;

    assign wdog_en  = imem_req_o && !imem_ack_i;
    assign wdog_clr = imem_ack_i ||
                      ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_SQUASH)));

    fetch_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wdog_clr),
        .cnt_en_i  (wdog_en),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            S_FETCH: begin
                // Remember the address on the wire in case a redirect forces a squash.
                req_addr_d = pc_q;
                if (redirect_bad) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_MISALIGNED;
                end else if (wdog_expired) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_ACK_TIMEOUT;
                end else if (redirect_ok) begin
                    pc_d = redirect_pc_i;
                    if (!imem_ack_i) begin
                        state_d = S_SQUASH;
                    end
                end else if (imem_ack_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = S_VALID;
                end
            end

            S_SQUASH: begin
                if (redirect_bad) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_MISALIGNED;
                end else if (wdog_expired) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_ACK_TIMEOUT;
                end else begin
                    if (redirect_ok) begin
                        pc_d = redirect_pc_i;
                    end
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_VALID: begin
                if (redirect_bad) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_MISALIGNED;
                end else if (redirect_ok) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_FETCH;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            inst_q       <= INST_NOP;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign inst_valid_o  = (state_q == S_VALID);
    assign inst_o        = inst_q;
    assign inst_opcode_o = inst_q[6:0];
    assign pc_o          = pc_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table of fetches plus hand-written redirect/fault sequences.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [6:0]  inst_opcode_o;
    logic [31:0] pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fault_o;
    logic [1:0]  fault_code_o;

    inst_fetch #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_opcode_o (inst_opcode_o),
        .pc_o          (pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .fault_o       (fault_o),
        .fault_code_o  (fault_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        cycle();
        cycle();
        chk("rst_req",    {31'b0, imem_req_o},   32'd0);
        chk("rst_addr",   imem_addr_o,           32'h0);
        chk("rst_valid",  {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst",   inst_o,                32'h0000_0013);
        chk("rst_opcode", {25'b0, inst_opcode_o}, 32'h13);
        chk("rst_pc",     pc_o,                  32'h0);
        chk("rst_fault",  {31'b0, fault_o},      32'd0);
        chk("rst_code",   {30'b0, fault_code_o}, 32'd0);
        rst_i = 1'b0;
        #1;
    endtask

    // Memory answers after ack_dly idle cycles; decode accepts after rdy_dly stalled cycles.
    task automatic serve(input vec_t v);
        exp_t e;
        for (int i = 0; i <= v.ack_dly; i++) begin
            chk("req_hi",    {31'b0, imem_req_o},   32'd1);
            chk("req_addr",  imem_addr_o,           v.exp_pc);
            chk("req_novld", {31'b0, inst_valid_o}, 32'd0);
            if (i == v.ack_dly) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = v.exp_inst;
                e.pc   = v.exp_pc;
                e.inst = v.exp_inst;
                sb.push_back(e);
            end
            cycle();
            clear_inputs();
        end
        for (int j = 0; j <= v.rdy_dly; j++) begin
            chk("vld_hi",  {31'b0, inst_valid_o}, 32'd1);
            chk("vld_req", {31'b0, imem_req_o},   32'd0);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                chk("vld_inst",   inst_o,                 sb[0].inst);
                chk("vld_pc",     pc_o,                   sb[0].pc);
                chk("vld_opcode", {25'b0, inst_opcode_o}, {25'b0, sb[0].inst[6:0]});
            end
            if (j == v.rdy_dly) begin
                inst_ready_i = 1'b1;
                if (sb.size() != 0) void'(sb.pop_front());
            end
            cycle();
            clear_inputs();
        end
    endtask

    task automatic serve4(input int a, input int r, input logic [31:0] pc, input logic [31:0] inst);
        vec_t v;
        v.ack_dly  = a;
        v.rdy_dly  = r;
        v.exp_pc   = pc;
        v.exp_inst = inst;
        serve(v);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0000, 32'h0050_0093};
        vecs[1] = '{0, 0, 32'h0000_0004, 32'h0050_0493};
        vecs[2] = '{3, 4, 32'h0000_0008, 32'h0050_0833};
        vecs[3] = '{1, 0, 32'h0000_000C, 32'h0000_A003};
        vecs[4] = '{0, 2, 32'h0000_0010, 32'h0000_006F};

        do_reset();
        for (int k = 0; k < 5; k++) serve(vecs[k]);

        // Reset while the request to 0x14 is outstanding, with an ack landing during reset.
        chk("pre_rst_addr", imem_addr_o, 32'h14);
        imem_ack_i = 1'b1;
        rst_i      = 1'b1;
        #1;
        chk("midrst_req", {31'b0, imem_req_o}, 32'd0);
        do_reset();

        // Redirect while the request to 0x8 waits: squash it, then fetch 0x100.
        serve4(0, 0, 32'h0, 32'h0050_0093);
        serve4(0, 0, 32'h4, 32'h0050_0493);
        chk("sq_addr0", imem_addr_o, 32'h8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("sq_req",   {31'b0, imem_req_o},   32'd1);
            chk("sq_addr",  imem_addr_o,           32'h8);
            chk("sq_novld", {31'b0, inst_valid_o}, 32'd0);
            if (i == 2) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = 32'h0050_0893;
            end
            cycle();
            clear_inputs();
        end
        chk("sq_after_vld", {31'b0, inst_valid_o}, 32'd0);
        serve4(0, 0, 32'h100, 32'h0010_0113);

        // Ack and redirect in the same cycle: data dropped, fetch retargets.
        chk("ar_addr", imem_addr_o, 32'h104);
        imem_ack_i    = 1'b1;
        imem_rdata_i  = 32'h0000_0063;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        clear_inputs();
        chk("ar_novld", {31'b0, inst_valid_o}, 32'd0);
        chk("ar_req",   {31'b0, imem_req_o},   32'd1);
        chk("ar_addr2", imem_addr_o,           32'h200);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h0020_0213;
        cycle();
        clear_inputs();

        // Redirect beats ready while valid.
        chk("rv_vld",  {31'b0, inst_valid_o}, 32'd1);
        chk("rv_inst", inst_o,                32'h0020_0213);
        chk("rv_pc",   pc_o,                  32'h200);
        inst_ready_i  = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        clear_inputs();
        chk("rv_novld", {31'b0, inst_valid_o}, 32'd0);
        serve4(0, 0, 32'hFFFF_FFFC, 32'h0000_0033);
        serve4(0, 0, 32'h0000_0000, 32'h0050_0093);

        // Misaligned redirect faults; fault is sticky until reset.
        chk("mis_addr", imem_addr_o, 32'h4);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("mis_fault", {31'b0, fault_o},      32'd1);
            chk("mis_code",  {30'b0, fault_code_o}, 32'd2);
            chk("mis_req",   {31'b0, imem_req_o},   32'd0);
            chk("mis_vld",   {31'b0, inst_valid_o}, 32'd0);
            chk("mis_pc",    pc_o,                  32'h4);
            imem_ack_i    = 1'b1;
            inst_ready_i  = 1'b1;
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h40;
            cycle();
            clear_inputs();
        end
        do_reset();

        // No ack at all: timeout after 4 request cycles.
        for (int i = 0; i < 4; i++) begin
            chk("to_req",   {31'b0, imem_req_o}, 32'd1);
            chk("to_nofault", {31'b0, fault_o},  32'd0);
            cycle();
        end
        chk("to_fault", {31'b0, fault_o},      32'd1);
        chk("to_code",  {30'b0, fault_code_o}, 32'd1);
        chk("to_req_lo", {31'b0, imem_req_o},  32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
